// File: rtl/msfsm_env_pkg.sv
// Shared definitions for the Petri-net driver: FSM states, net topology
// masks and a small priority helper used by the autonomous picker.
package msfsm_env_pkg;

    localparam int NUM_PLACES = 10;
    localparam int NUM_TRANS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GAP
    } state_t;

    // Marking after reset: one token in p0 and one in p1.
    localparam logic [NUM_PLACES-1:0] INIT_MARKING = 10'h003;

    // Input places of each transition; entry i belongs to transition ti.
    localparam logic [NUM_TRANS-1:0][NUM_PLACES-1:0] PRE = {
        10'h100,   // t7: p8
        10'h020,   // t6: p5
        10'h010,   // t5: p4
        10'h001,   // t4: p0
        10'h002,   // t3: p1
        10'h004,   // t2: p2
        10'h001,   // t1: p0
        10'h2C8    // t0: p3,p6,p7,p9
    };

    // Output places of each transition; entry i belongs to transition ti.
    localparam logic [NUM_TRANS-1:0][NUM_PLACES-1:0] POST = {
        10'h200,   // t7: p9
        10'h080,   // t6: p7
        10'h040,   // t5: p6
        10'h008,   // t4: p3
        10'h130,   // t3: p4,p5,p8
        10'h008,   // t2: p3
        10'h004,   // t1: p2
        10'h003    // t0: p0,p1
    };

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [2:0] lowestIndex(input logic [NUM_TRANS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_TRANS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/msfsm_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that only steps when told to,
// used to break the free choice at p0.
module msfsm_lfsr (
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic        feedback_d;

    assign feedback_d = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign q          = lfsr_q;

    // Shift right with the tap parity entering at the top, only on adv.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= seed;
        end else if (adv) begin
            lfsr_q <= {feedback_d, lfsr_q[15:1]};
        end
    end

endmodule

// File: rtl/msfsm_env_driver.sv
// Drives the transition strobes of a 10-place / 8-transition Petri net,
// either on explicit request or autonomously, and tracks the marking.
module msfsm_env_driver
    import msfsm_env_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [2:0]       req_tr,
    output logic             req_ready,
    input  logic             auto_en,
    output logic             t0,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             t5,
    output logic             t6,
    output logic             t7,
    output logic [9:0]       marking,
    output logic [7:0]       enabled,
    output logic             err_not_enabled,
    output logic             deadlock,
    output logic [CNT_W-1:0] fire_count
);

    state_t                  state_q;
    logic [NUM_PLACES-1:0]   marking_q;
    logic [NUM_PLACES-1:0]   marking_d;
    logic [CNT_W-1:0]        fireCount_q;
    logic [2:0]              tr_q;
    logic [NUM_TRANS-1:0]    strobe_q;
    logic                    err_q;
    logic [2:0]              autoTr_d;
    logic                    autoFire_d;
    logic [15:0]             lfsrQ;
    logic                    unusedLfsrBits;

    // Only bit 0 of the LFSR steers the choice; the rest is its internal state.
    assign unusedLfsrBits = ^lfsrQ[15:1];

    msfsm_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (autoFire_d),
        .seed  (LFSR_SEED),
        .q     (lfsrQ)
    );

    // A transition is enabled when every one of its input places holds a token.
    always_comb begin
        enabled = '0;
        for (int i = 0; i < NUM_TRANS; i++) begin
            enabled[i] = (marking_q & PRE[i]) == PRE[i];
        end
    end

    // Autonomous pick: LFSR resolves the p0 conflict, otherwise lowest index wins.
    always_comb begin
        autoTr_d = lowestIndex(enabled);
        if (enabled[1] && enabled[4]) begin
            autoTr_d = lfsrQ[0] ? 3'd4 : 3'd1;
        end
    end

    assign autoFire_d = (state_q == IDLE) && !req_valid && auto_en && (enabled != '0);
    assign marking_d  = (marking_q & ~PRE[tr_q]) | POST[tr_q];

    // IDLE accepts a request or an auto pick, FIRE strobes and commits, GAP spaces firings.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            marking_q   <= INIT_MARKING;
            fireCount_q <= '0;
            tr_q        <= '0;
            strobe_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (enabled[req_tr]) begin
                            tr_q     <= req_tr;
                            strobe_q <= 8'd1 << req_tr;
                            state_q  <= FIRE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (autoFire_d) begin
                        tr_q     <= autoTr_d;
                        strobe_q <= 8'd1 << autoTr_d;
                        state_q  <= FIRE;
                    end
                end
                FIRE: begin
                    marking_q   <= marking_d;
                    fireCount_q <= fireCount_q + CNT_W'(1);
                    strobe_q    <= '0;
                    state_q     <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    strobe_q <= '0;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign marking         = marking_q;
    assign fire_count      = fireCount_q;
    assign err_not_enabled = err_q;
    assign deadlock        = (enabled == '0);
    assign {t7, t6, t5, t4, t3, t2, t1, t0} = strobe_q;

endmodule

// File: doc/msfsm_env_driver.md
MSFSM_ENV_DRIVER -- requirements
Module: msfsm_env_driver

Interface
REQ-001 The block SHALL have parameter LFSR_SEED, default 16'hACE1, initial value of the choice LFSR (non-zero).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of fire_count.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  request to fire transition req_tr.
REQ-006 The block SHALL have port req_tr  input  3  index 0..7 of the requested transition.
REQ-007 The block SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-008 The block SHALL have port auto_en  input  1  autonomous firing when no request is pending.
REQ-009 The block SHALL have ports t0..t7  output  1 each  one-cycle firing strobes, wired directly to MSFSM transition inputs.
REQ-010 The block SHALL have port marking  output  10  current marking, bit i = place pi.
REQ-011 The block SHALL have port enabled  output  8  combinational enabled set of the current marking.
REQ-012 The block SHALL have port err_not_enabled  output  1  one-cycle pulse when a request targets a disabled transition.
REQ-013 The block SHALL have port deadlock  output  1  high while enabled == 0.
REQ-014 The block SHALL have port fire_count  output  CNT_W  number of transitions fired since reset, wrapping.

Function
REQ-015 The net SHALL be: t1 p0->p2; t4 p0->p3; t2 p2->p3; t3 p1->{p4,p5,p8}; t5 p4->p6; t6 p5->p7; t7 p8->p9; t0 {p3,p6,p7,p9}->{p0,p1}.
REQ-016 Transition ti SHALL be enabled iff (marking & PRE[i]) == PRE[i].
REQ-017 The FSM SHALL have states IDLE, FIRE, GAP; IDLE->FIRE on accepted enabled request or auto pick; FIRE->GAP always; GAP->IDLE always.
REQ-018 Exactly one t strobe SHALL be high during FIRE and all t strobes SHALL be low in IDLE and GAP.
REQ-019 At the end of FIRE the marking SHALL become (marking & ~PRE[i]) | POST[i], and fire_count SHALL increment modulo 2^CNT_W.
REQ-020 Latency SHALL be fixed: request accepted in cycle N gives the strobe in cycle N+1 and the new marking in cycle N+2, with the next acceptance no earlier than N+3.
REQ-021 An accepted request for a disabled transition SHALL produce err_not_enabled in cycle N+1, leave the marking unchanged, and keep the FSM in IDLE.
REQ-022 req_valid SHALL have priority over auto_en in the same IDLE cycle.
REQ-023 Auto pick SHALL be made in IDLE with auto_en=1 and req_valid=0, as follows:
- If t1 and t4 are both enabled (the free choice at p0), pick t4 when lfsr[0]=1, else t1.
- Otherwise pick the lowest-index enabled transition.
- If nothing is enabled, stay in IDLE.
REQ-024 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing only on cycles an auto pick is made.
REQ-025 req_tr SHALL be sampled only on acceptance; changes while req_ready=0 SHALL be ignored.

Reset
REQ-026 Reset SHALL force, asynchronously, within the same cycle:
- state IDLE, marking 10'h003 (p0,p1), fire_count 0, lfsr LFSR_SEED;
- t0..t7 low, err_not_enabled low.
REQ-027 Reset asserted during FIRE or GAP SHALL abort the firing with no marking update, and the strobe SHALL drop immediately.

Structure
REQ-028 Package msfsm_env_pkg SHALL hold the state enum, the PRE[8]/POST[8] 10-bit masks, INIT_MARKING, and the place/transition count constants.
REQ-029 The LFSR SHALL be a sub-module msfsm_lfsr (ports clk, reset, adv, seed, q[15:0]); all else SHALL be in one module.

Verification
REQ-030 Release reset, then check marking=10'h003, enabled=8'h1A, req_ready=1, deadlock=0, fire_count=0.
REQ-031 From reset, request t3 in cycle N: t3=1 only in N+1, marking=10'h131 in N+2, req_ready=1 in N+3.
REQ-032 From reset, request t0: err_not_enabled pulses in N+1, no t strobe, marking stays 10'h003.
REQ-033 Request sequence t1,t2,t3,t7,t6,t5,t0: every request is accepted, the final marking is 10'h003, and fire_count=7.
REQ-034 Assert reset in the FIRE cycle of t3: t3 drops immediately, marking=10'h003, fire_count=0.
REQ-035 Run with auto_en=1 for 1000 cycles, no requests:
- exactly one strobe per 3 cycles;
- deadlock never high;
- both t1 and t4 are fired at least once;
- every fire respects REQ-016.
